// File: rtl/num_compose.sv
// Keypad decimal entry: 4-digit BCD entry register with sign, converted by a
// multi-cycle Horner loop into a 16-bit two's-complement operand.
module num_compose #(
   parameter int NDIG = 4
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic               dig_vld,
   input  logic [3:0]         dig,
   input  logic               neg_tog,
   input  logic               bksp,
   input  logic               clr,
   output logic               rdy,
   output logic signed [15:0] v,
   output logic               v_vld,
   output logic [3:0]         thd,
   output logic [3:0]         hud,
   output logic [3:0]         ten,
   output logic [3:0]         one,
   output logic               neg,
   output logic [2:0]         cnt,
   output logic               ovf
);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t                   state_q;
   logic [3:0][3:0]          digs_q, digs_d;
   logic [2:0]               cnt_q, cnt_d;
   logic                     neg_q, neg_d;
   logic                     ovf_q, ovf_d;
   logic                     start_d;
   logic [13:0]              acc_q;
   logic [1:0]               idx_q;
   logic signed [15:0]       v_q;
   logic                     v_vld_q;

   function automatic logic [13:0] horner_step(input logic [13:0] acc, input logic [3:0] d);
      return (acc << 3) + (acc << 1) + {10'd0, d};
   endfunction

   function automatic logic signed [15:0] apply_sign(input logic [13:0] mag, input logic sgn);
      logic signed [15:0] wide;
      wide = $signed({2'b00, mag});
      return sgn ? -wide : wide;
   endfunction

   // Event decode: clr always wins; other events only when idle, in priority order.
   always_comb begin
      digs_d  = digs_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      ovf_d   = 1'b0;
      start_d = 1'b0;
      if (clr) begin
         digs_d = '0;
         cnt_d  = 3'd0;
         neg_d  = 1'b0;
      end else if (state_q == IDLE) begin
         if (bksp) begin
            if (cnt_q != 3'd0) begin
               digs_d  = {4'd0, digs_q[3:1]};
               cnt_d   = cnt_q - 3'd1;
               if (cnt_q == 3'd1) neg_d = 1'b0;
               start_d = 1'b1;
            end
         end else if (neg_tog) begin
            if (cnt_q != 3'd0) begin
               neg_d   = ~neg_q;
               start_d = 1'b1;
            end
         end else if (dig_vld && dig <= 4'd9) begin
            if (cnt_q >= 3'(NDIG)) begin
               ovf_d = 1'b1;
            end else if (!(cnt_q == 3'd0 && dig == 4'd0)) begin
               digs_d  = {digs_q[2:0], dig};
               cnt_d   = cnt_q + 3'd1;
               start_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= IDLE;
         digs_q  <= '0;
         cnt_q   <= 3'd0;
         neg_q   <= 1'b0;
         ovf_q   <= 1'b0;
         acc_q   <= 14'd0;
         idx_q   <= 2'd0;
         v_q     <= '0;
         v_vld_q <= 1'b0;
      end else begin
         digs_q  <= digs_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         ovf_q   <= ovf_d;
         v_vld_q <= 1'b0;
         if (clr) begin
            state_q <= IDLE;
            v_q     <= '0;
            v_vld_q <= 1'b1;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start_d) begin
                     state_q <= CONV;
                     acc_q   <= 14'd0;
                     idx_q   <= 2'd3;
                  end
               end
               // Most significant digit first: thd at idx 3 down to one at idx 0.
               CONV: begin
                  acc_q <= horner_step(acc_q, digs_q[idx_q]);
                  idx_q <= idx_q - 2'd1;
                  if (idx_q == 2'd0) state_q <= DONE;
               end
               DONE: begin
                  v_q     <= apply_sign(acc_q, neg_q);
                  v_vld_q <= 1'b1;
                  state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign rdy   = (state_q == IDLE);
   assign v     = v_q;
   assign v_vld = v_vld_q;
   assign thd   = digs_q[3];
   assign hud   = digs_q[2];
   assign ten   = digs_q[1];
   assign one   = digs_q[0];
   assign neg   = neg_q;
   assign cnt   = cnt_q;
   assign ovf   = ovf_q;

endmodule

// File: doc/num_compose.md
# num_compose

Keypad-side decimal entry accumulator for the calculator: the inverse of the digit-split display path. Digits, sign toggle, backspace and clear arrive as single-cycle pulses. The block keeps a 4-digit BCD entry register plus a sign flag and converts them with a multi-cycle Horner loop into a 16-bit two's-complement operand for the arithmetic units. The BCD digits and sign are also exported so the display can echo the entry directly.

## Interface
- NDIG, 4: number of BCD digits held; fixed at 4, giving magnitude ≤ 9999.
- sys_clk  in  1  single system clock, rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- dig_vld  in  1  one-cycle pulse; `dig` is valid.
- dig  in  4  BCD digit 0–9; codes 10–15 are ignored.
- neg_tog  in  1  one-cycle pulse; toggles the sign.
- bksp  in  1  one-cycle pulse; removes the last entered digit.
- clr  in  1  one-cycle pulse; clears the entry. Accepted even while busy.
- rdy  out  1  high in IDLE; `dig_vld`, `neg_tog` and `bksp` are accepted only when `rdy`=1.
- v  out  16  signed entry value, two's complement.
- v_vld  out  1  one-cycle pulse when `v` has just been updated.
- thd, hud, ten, one  out  4 each  BCD digits of the entry; `one` holds the most recent digit.
- neg  out  1  sign flag.
- cnt  out  3  number of digits entered, 0–4.
- ovf  out  1  one-cycle pulse when a digit is rejected because `cnt`=4.

## Operation
- **Priority in one cycle:** clr > bksp > neg_tog > dig_vld. Only the highest-priority event is acted on; the others are dropped.
- **Digit:** applies if `dig`≤9 and `cnt`<4.
  - Shift: thd←hud, hud←ten, ten←one, one←dig; `cnt`+1.
  - Digit 0 while `cnt`=0 is ignored (no leading zeros).
  - With `cnt`=4: registers unchanged, `ovf` pulses, no conversion.
  - `dig`≥10: ignored, no conversion, no `ovf`.
- **Backspace:** applies if `cnt`>0.
  - Shift: one←ten, ten←hud, hud←thd, thd←0; `cnt`−1.
  - If `cnt` becomes 0, `neg`←0.
  - With `cnt`=0 it is ignored.
- **Sign toggle:** `neg`←~`neg` only if `cnt`>0; otherwise ignored.
- **Clear:**
  - Digits, `cnt` and `neg` go to 0.
  - Any conversion in progress is aborted and the FSM goes to IDLE.
  - At the same edge `v`←0; `v_vld` is high in the following cycle.
- **Conversion trigger:** every applied digit, backspace or toggle starts a conversion. Ignored events do not.
- **FSM states:** IDLE, CONV, DONE.
  - IDLE→CONV on an applied event; acc←0, idx←3.
  - CONV runs four cycles, idx = 3,2,1,0, over digit vector {thd,hud,ten,one}. Each cycle: acc ← (acc<<3)+(acc<<1)+d[idx].
  - CONV→DONE after idx=0.
  - DONE: v ← neg ? −acc : acc; `v_vld`=1 for that cycle; then →IDLE.
- **Arithmetic:** acc is 14 bits, unsigned, maximum 9999, so overflow is impossible. Negation is done in 16 bits. Range is −9999..9999. `neg` with value 0 cannot occur.
- `rdy` = (state==IDLE). Non-clear pulses arriving while `rdy`=0 are ignored without any flag.

## Timing
- **Reset values:** `v`=0, `v_vld`=0, digits=0, `neg`=0, `cnt`=0, `ovf`=0, state IDLE, `rdy`=1.
- **Reset mid-conversion:** immediate return to IDLE with all outputs at their reset values; no `v_vld` is emitted.
- **Event update:** the event is sampled at edge E0. Digits, `cnt` and `neg` update at E0.
- **Conversion latency:** CONV occupies the cycles after E0 through E4. DONE follows, `v` updates at E5, and `v_vld` is high in the cycle after E5. `rdy` returns high after the DONE cycle.
- **Throughput:** accepted events are spaced at least 6 cycles apart.
- **`ovf`:** high for exactly the one cycle after the rejected digit's edge.
- **Clear:** `v`=0 and `v_vld` pulse one cycle after the clear edge, whatever the state.

## Test plan
- Digits 1,2,3,4, each applied when `rdy`=1:
  - After the final `v_vld`: `v`=0x04D2, thd..one=1,2,3,4, `cnt`=4.
  - Exactly four `v_vld` pulses in total: 0x0001, 0x000C, 0x007B, 0x04D2.
- From 1234:
  - `neg_tog` → `v`=0xFB2E.
  - Then digit 5 → `ovf` pulse, no `v_vld`, entry unchanged.
  - Then `bksp` → `v`=0xFF85 (−123), `cnt`=3, `neg`=1.
- From −7:
  - `bksp` → `cnt`=0, `neg`=0, `v`=0x0000.
  - Then `neg_tog` and digit 0 → both ignored; `rdy` stays 1, no `v_vld`.
- Enter 9: digit 9 sampled with `rdy`=1, then digit 8 pulsed while `rdy`=0 → the 8 is ignored; final `v`=0x0009, `cnt`=1.
- Enter 9,9,9 (`v`=999), then apply digit 9:
  - `clr` 2 cycles after that digit → conversion aborted; `v`=0 with a `v_vld` pulse one cycle after the clear edge; no later `v_vld`.
  - Then `clr` together with `dig_vld`(5) in the same cycle → clear wins, `cnt`=0.
- Enter 4,2, then assert `sys_rst_n` low mid-CONV → all outputs at reset values, `rdy`=1 after release, no spurious `v_vld`.
